// File: rtl/trunc_mul_pkg.sv
// trunc_mul_pkg: shared defaults and FSM state type for the truncated-multiplier datapath.
package trunc_mul_pkg;
    localparam int PW_DEF        = 8;
    localparam int ACC_W_DEF     = 16;
    localparam int COMP_BIAS_DEF = 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } state_t;
endpackage

// File: rtl/trunc_prod_accum_if.sv
// trunc_prod_accum_if: product input and group-total output handshakes of the accumulator.
interface trunc_prod_accum_if #(
    parameter int PW    = 8,
    parameter int ACC_W = 16,
    parameter int CNT_W = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [PW-1:0]    in_prod;
    logic             in_last;
    logic             out_valid;
    logic             out_ready;
    logic [ACC_W-1:0] out_sum;
    logic [CNT_W-1:0] out_count;
    logic             out_ovf;

    modport master (
        output in_valid, in_prod, in_last, out_ready,
        input  in_ready, out_valid, out_sum, out_count, out_ovf
    );

    modport slave (
        input  in_valid, in_prod, in_last, out_ready,
        output in_ready, out_valid, out_sum, out_count, out_ovf
    );
endinterface

// File: rtl/trunc_prod_accum_sat_add.sv
// sat_add: unsigned saturating add of a W-bit accumulator and a (W+1)-bit addend.
module sat_add #(
    parameter int W = 16
) (
    input  logic [W-1:0] a_i,
    input  logic [W:0]   b_i,
    output logic [W-1:0] sum_o,
    output logic         ovf_o
);
    logic [W+1:0] full;

    assign full  = {2'b00, a_i} + {1'b0, b_i};
    assign ovf_o = |full[W+1:W];
    assign sum_o = ovf_o ? '1 : full[W-1:0];
endmodule

// File: rtl/trunc_prod_accum.sv
// trunc_prod_accum: groups truncated products into saturating sums with sticky overflow.
// Build macro TRUNC_COMP_EN adds COMP_BIAS to every accepted product.
module trunc_prod_accum
    import trunc_mul_pkg::*;
#(
    parameter int PW        = PW_DEF,
    parameter int ACC_W     = ACC_W_DEF,
    parameter int LEN       = 8,
    parameter int CNT_W     = 8,
    parameter int COMP_BIAS = COMP_BIAS_DEF
) (
    input logic               clk,
    input logic               rst,
    trunc_prod_accum_if.slave bus
);
    if (ACC_W < PW || LEN < 1 || LEN > 255 || LEN > (1 << CNT_W) - 1 || COMP_BIAS < 0) begin : g_bad_cfg
        $error("trunc_prod_accum: illegal parameter set");
    end

    state_t           state_q, state_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ovf_q, ovf_d;
    logic [ACC_W-1:0] out_sum_q;
    logic [CNT_W-1:0] out_count_q;
    logic             out_ovf_q;
    logic [ACC_W:0]   addend;
    logic             add_ovf;
    logic             accept;
    logic             cnt_full;
    logic             close;
    logic             handshake;

`ifdef TRUNC_COMP_EN
    assign addend = (ACC_W+1)'(bus.in_prod) + (ACC_W+1)'(COMP_BIAS);
`else
    assign addend = (ACC_W+1)'(bus.in_prod);
`endif

    // acc is zero whenever the FSM is in IDLE, so a new group starts from 0
    sat_add #(.W(ACC_W)) u_add (
        .a_i   (acc_q),
        .b_i   (addend),
        .sum_o (acc_d),
        .ovf_o (add_ovf)
    );

    assign accept    = bus.in_valid & bus.in_ready;
    assign cnt_d     = cnt_q + 1'b1;
    assign ovf_d     = ovf_q | add_ovf;
    assign cnt_full  = ({1'b0, cnt_q} + 1'b1) == (CNT_W+1)'(LEN);
    assign close     = accept & (bus.in_last | cnt_full);
    assign handshake = (state_q == HOLD) & bus.out_ready;

    always_ff @(posedge clk or posedge rst)
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;

    always_comb begin
        state_d = state_q;
        if (state_q == HOLD) state_d = bus.out_ready ? IDLE : HOLD;
        else if (accept)     state_d = close ? HOLD : ACCUM;
    end

    always_comb begin
        bus.in_ready  = state_q != HOLD;
        bus.out_valid = state_q == HOLD;
    end

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            acc_q <= '0;
            cnt_q <= '0;
            ovf_q <= 1'b0;
        end else if (handshake) begin
            acc_q <= '0;
            cnt_q <= '0;
            ovf_q <= 1'b0;
        end else if (accept) begin
            acc_q <= acc_d;
            cnt_q <= cnt_d;
            ovf_q <= ovf_d;
        end

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            out_sum_q   <= '0;
            out_count_q <= '0;
            out_ovf_q   <= 1'b0;
        end else if (close) begin
            out_sum_q   <= acc_d;
            out_count_q <= cnt_d;
            out_ovf_q   <= ovf_d;
        end

    assign bus.out_sum   = out_sum_q;
    assign bus.out_count = out_count_q;
    assign bus.out_ovf   = out_ovf_q;
endmodule
